gate_unit_arbiter: RTL and testbench
====================================

Name: gate_unit_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit between NUM_REQ requesters.
- The logic unit supports NOT, BUF, AND, OR, NAND, NOR, XOR and XNOR.
- Each requester submits an opcode and operands over a valid/ready handshake. A round-robin arbiter grants one requester per cycle.
- The result is registered into a single-entry response slot tagged with the requester id. The block sits between the per-lane command sources and the shared gate datapath.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16. ID_W = $clog2(NUM_REQ) is a derived localparam.
- WIDTH, 8, operand and result width in bits.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- req_valid_in  input  NUM_REQ  bit i: requester i has a command.
- req_ready_out  output  NUM_REQ  bit i: command i is accepted this cycle. At most one bit is high.
- req_op_in  input  3*NUM_REQ  opcode of requester i, bits [3i+2:3i].
- req_a_in  input  WIDTH*NUM_REQ  operand a of requester i.
- req_b_in  input  WIDTH*NUM_REQ  operand b of requester i.
- rsp_valid_out  output  1  response slot full.
- rsp_ready_in  input  1  consumer takes the response.
- rsp_id_out  output  ID_W  index of the requester that issued the response.
- rsp_data_out  output  WIDTH  result.
- busy_out  output  1  equals rsp_valid_out OR any req_valid_in bit.
- done_cnt_out  output  CNT_W  number of responses consumed; wraps modulo 2^CNT_W.

Behaviour:
- Reset: while rst_n_in is low, regardless of clock:
  - rsp_valid_out = 0, rsp_id_out = 0, rsp_data_out = 0;
  - round-robin pointer = 0;
  - done_cnt_out = 0.
  - req_ready_out is all-zero while rst_n_in is low.
- Reset mid-operation: any pending response is discarded and not counted. Requesters must re-present their commands.
- Opcode map (b is ignored for opcodes 0 and 1):
  - 0: ~a
  - 1: a
  - 2: a&b
  - 3: a|b
  - 4: ~(a&b)
  - 5: ~(a|b)
  - 6: a^b
  - 7: ~(a^b)
- Slot free condition: slot_free = !rsp_valid_out OR rsp_ready_in.
  - Pass-through is allowed: the slot can be drained and refilled in the same cycle.
- Arbitration is combinational in the same cycle:
  - Scan req_valid_in starting at index ptr, upward with wrap, and pick the first set bit g.
  - req_ready_out[g] = slot_free; all other bits are 0.
  - If no valid bit is set, req_ready_out = 0.
- Accept occurs when req_valid_in[g] AND req_ready_out[g]. On the next edge:
  - rsp_data_out = op(a_g, b_g);
  - rsp_id_out = g;
  - rsp_valid_out = 1;
  - ptr = (g+1) mod NUM_REQ.
  - Latency is 1 cycle from accept to rsp_valid_out.
- No accept:
  - If rsp_valid_out AND rsp_ready_in, then rsp_valid_out goes to 0.
  - rsp_data_out and rsp_id_out hold their last values.
  - ptr is unchanged.
- Backpressure: while rsp_valid_out = 1 and rsp_ready_in = 0, rsp_data_out and rsp_id_out are stable and req_ready_out = 0.
- done_cnt_out increments by 1 on every cycle with rsp_valid_out AND rsp_ready_in. It wraps from 2^CNT_W-1 to 0.
- Requester rules:
  - Once req_valid_in[i] is asserted, it stays high with stable op, a and b until req_ready_out[i] is seen.
  - The arbiter does not check this rule.
  - Dropping valid before accept is permitted; the command is simply not executed.
- Fairness: with all requesters continuously valid and rsp_ready_in = 1, grants are issued in order 0,1,2,...,NUM_REQ-1,0,... with one grant per cycle. No requester waits more than NUM_REQ-1 grants.
- Throughput: 1 operation per cycle when rsp_ready_in is held high.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst_n_in low mid-cycle.
  - Response: outputs go to 0 immediately. After release with no requests, busy_out = 0 and req_ready_out = 0.
- Opcode sweep:
  - Stimulus: requester 2 only, a=8'hC5, b=8'h3A, ops 0..7 issued back-to-back with rsp_ready_in = 1.
  - Response: rsp_data_out = 3A, C5, 00, FF, FF, 00, FF, 00, each with rsp_id_out = 2. done_cnt_out = 8.
- Round-robin:
  - Stimulus: all 4 requesters hold valid, rsp_ready_in = 1, for 8 cycles.
  - Response: rsp_id_out sequence is 0,1,2,3,0,1,2,3 on consecutive cycles.
- Backpressure:
  - Stimulus: response pending, rsp_ready_in = 0 for 5 cycles, requesters 1 and 3 valid.
  - Response: req_ready_out = 0 and rsp_data_out/rsp_id_out stable throughout. When rsp_ready_in rises, the next grant is issued in that same cycle (pass-through).
- Pointer skip:
  - Stimulus: ptr = 1, only requester 0 valid.
  - Response: requester 0 is granted, then ptr = 1.
- Counter wrap and mid-reset:
  - Stimulus: CNT_W = 4, 17 responses consumed, then reset pulsed while a response is pending.
  - Response: done_cnt_out = 1 before the reset. After reset, rsp_valid_out = 0, done_cnt_out = 0, and the dropped response is not counted.

Source files
------------

// File: rtl/gate_unit_arbiter_if.sv
// Command/response bundle between the per-lane command sources, the shared
// gate datapath arbiter and the response consumer.
interface gate_unit_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 16
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; the source holds valid and its payload stable until then.
    logic [NUM_REQ-1:0]       req_valid_in;
    logic [NUM_REQ-1:0]       req_ready_out;
    logic [3*NUM_REQ-1:0]     req_op_in;
    logic [WIDTH*NUM_REQ-1:0] req_a_in;
    logic [WIDTH*NUM_REQ-1:0] req_b_in;
    logic                     rsp_valid_out;
    logic                     rsp_ready_in;
    logic [ID_W-1:0]          rsp_id_out;
    logic [WIDTH-1:0]         rsp_data_out;
    logic                     busy_out;
    logic [CNT_W-1:0]         done_cnt_out;

    modport slave (
        input  req_valid_in, req_op_in, req_a_in, req_b_in, rsp_ready_in,
        output req_ready_out, rsp_valid_out, rsp_id_out, rsp_data_out,
               busy_out, done_cnt_out
    );

    modport master (
        output req_valid_in, req_op_in, req_a_in, req_b_in, rsp_ready_in,
        input  req_ready_out, rsp_valid_out, rsp_id_out, rsp_data_out,
               busy_out, done_cnt_out
    );
endinterface

// File: rtl/gate_unit_arbiter.sv
// Round-robin sharing of one bitwise logic unit between NUM_REQ requesters,
// with a single registered response slot tagged by requester id.
module gate_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 16
) (
    input logic               clk_in,
    input logic               rst_n_in,
    gate_unit_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  grant_id;
    logic             grant_found;
    logic             slot_free;
    logic             accept;
    logic [2:0]       grant_op;
    logic [WIDTH-1:0] grant_a;
    logic [WIDTH-1:0] grant_b;
    logic [WIDTH-1:0] result;
    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [CNT_W-1:0] done_cnt_q;

    // Pass-through: a slot being drained this cycle may be refilled at once.
    assign slot_free = !rsp_valid_q || bus.rsp_ready_in;

    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!grant_found && bus.req_valid_in[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    // Ready is forced low during reset even though the slot reads as empty.
    assign accept = grant_found && slot_free && rst_n_in;

    always_comb begin
        bus.req_ready_out = '0;
        if (accept) begin
            bus.req_ready_out[grant_id] = 1'b1;
        end
    end

    assign grant_op = bus.req_op_in[3*grant_id +: 3];
    assign grant_a  = bus.req_a_in[WIDTH*grant_id +: WIDTH];
    assign grant_b  = bus.req_b_in[WIDTH*grant_id +: WIDTH];

    always_comb begin
        result = '0;
        case (grant_op)
            3'd0:    result = ~grant_a;
            3'd1:    result = grant_a;
            3'd2:    result = grant_a & grant_b;
            3'd3:    result = grant_a | grant_b;
            3'd4:    result = ~(grant_a & grant_b);
            3'd5:    result = ~(grant_a | grant_b);
            3'd6:    result = grant_a ^ grant_b;
            default: result = ~(grant_a ^ grant_b);
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            ptr_q       <= '0;
            done_cnt_q  <= '0;
        end else begin
            if (rsp_valid_q && bus.rsp_ready_in) begin
                done_cnt_q <= done_cnt_q + 1'b1;
            end
            if (accept) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= grant_id;
                rsp_data_q  <= result;
                if (int'(grant_id) == NUM_REQ - 1) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= grant_id + 1'b1;
                end
            end else if (rsp_valid_q && bus.rsp_ready_in) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid_out = rsp_valid_q;
    assign bus.rsp_id_out    = rsp_id_q;
    assign bus.rsp_data_out  = rsp_data_q;
    assign bus.done_cnt_out  = done_cnt_q;
    assign bus.busy_out      = rsp_valid_q || (|bus.req_valid_in);
endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter: opcode table, round-robin table and
// hand-written backpressure, pointer-skip, counter-wrap and reset sequences.
module tb_gate_unit_arbiter;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int CNT_W   = 4;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] exp_data;
    } op_vec_t;

    typedef struct {
        logic [1:0]       exp_id;
        logic [WIDTH-1:0] exp_data;
    } rr_vec_t;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    gate_unit_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    gate_unit_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [2:0] op,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.req_op_in[3*i +: 3]         = op;
        bus.req_a_in[WIDTH*i +: WIDTH]  = a;
        bus.req_b_in[WIDTH*i +: WIDTH]  = b;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    op_vec_t ops[8];
    rr_vec_t rr[8];
    logic [WIDTH-1:0] held_data;

    initial begin
        n_total = 0;
        n_pass  = 0;
        ops[0] = '{3'd0, 8'h3A};
        ops[1] = '{3'd1, 8'hC5};
        ops[2] = '{3'd2, 8'h00};
        ops[3] = '{3'd3, 8'hFF};
        ops[4] = '{3'd4, 8'hFF};
        ops[5] = '{3'd5, 8'h00};
        ops[6] = '{3'd6, 8'hFF};
        ops[7] = '{3'd7, 8'h00};
        for (int i = 0; i < 8; i++) begin
            rr[i].exp_id   = 2'(i % 4);
            rr[i].exp_data = 8'(((i % 4) * 8'h11) ^ 8'hF0);
        end

        // Reset then idle
        rst_n            = 1'b0;
        bus.req_valid_in = '0;
        bus.req_op_in    = '0;
        bus.req_a_in     = '0;
        bus.req_b_in     = '0;
        bus.rsp_ready_in = 1'b0;
        step();
        bus.req_valid_in = 4'b0001;
        #1;
        check("ready_in_reset", 32'(bus.req_ready_out), 32'h0);
        bus.req_valid_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_rsp_valid", 32'(bus.rsp_valid_out), 32'h0);
        check("idle_busy", 32'(bus.busy_out), 32'h0);
        check("idle_ready", 32'(bus.req_ready_out), 32'h0);
        check("idle_done_cnt", 32'(bus.done_cnt_out), 32'h0);

        // Opcode sweep on requester 2
        bus.rsp_ready_in = 1'b1;
        bus.req_valid_in = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            set_lane(2, ops[i].op, 8'hC5, 8'h3A);
            #1;
            check($sformatf("op%0d_ready", i), 32'(bus.req_ready_out), 32'h4);
            step();
            check($sformatf("op%0d_valid", i), 32'(bus.rsp_valid_out), 32'h1);
            check($sformatf("op%0d_id", i), 32'(bus.rsp_id_out), 32'h2);
            check($sformatf("op%0d_data", i), 32'(bus.rsp_data_out), 32'(ops[i].exp_data));
        end
        bus.req_valid_in = '0;
        step();
        check("sweep_done_cnt", 32'(bus.done_cnt_out), 32'd8);
        check("sweep_drained", 32'(bus.rsp_valid_out), 32'h0);

        // Round-robin from a fresh pointer
        pulse_reset();
        for (int i = 0; i < 4; i++) set_lane(i, 3'd6, 8'(i * 8'h11), 8'hF0);
        bus.req_valid_in = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("rr%0d_id", i), 32'(bus.rsp_id_out), 32'(rr[i].exp_id));
            check($sformatf("rr%0d_data", i), 32'(bus.rsp_data_out), 32'(rr[i].exp_data));
        end
        bus.req_valid_in = '0;
        step();
        check("rr_done_cnt", 32'(bus.done_cnt_out), 32'd8);

        // Backpressure with requesters 1 and 3
        set_lane(1, 3'd2, 8'hF0, 8'h3C);
        set_lane(3, 3'd3, 8'h0F, 8'h30);
        bus.rsp_ready_in = 1'b0;
        bus.req_valid_in = 4'b1010;
        #1;
        check("bp_first_ready", 32'(bus.req_ready_out), 32'h2);
        step();
        held_data = bus.rsp_data_out;
        check("bp_first_data", 32'(held_data), 32'h30);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_ready", i), 32'(bus.req_ready_out), 32'h0);
            check($sformatf("bp%0d_id", i), 32'(bus.rsp_id_out), 32'h1);
            check($sformatf("bp%0d_data", i), 32'(bus.rsp_data_out), 32'(held_data));
            check($sformatf("bp%0d_busy", i), 32'(bus.busy_out), 32'h1);
            step();
        end
        bus.rsp_ready_in = 1'b1;
        #1;
        check("bp_pass_ready", 32'(bus.req_ready_out), 32'h8);
        step();
        check("bp_pass_id", 32'(bus.rsp_id_out), 32'h3);
        check("bp_pass_data", 32'(bus.rsp_data_out), 32'h3F);
        bus.req_valid_in = '0;
        step();
        check("bp_done_cnt", 32'(bus.done_cnt_out), 32'd10);

        // Pointer skip: ptr sits at 0 -> grant 0 -> ptr 1 -> grant 0 again -> ptr 1
        set_lane(0, 3'd0, 8'h55, 8'h00);
        bus.req_valid_in = 4'b0001;
        step();
        check("skip_a_id", 32'(bus.rsp_id_out), 32'h0);
        check("skip_a_data", 32'(bus.rsp_data_out), 32'hAA);
        #1;
        check("skip_b_ready", 32'(bus.req_ready_out), 32'h1);
        step();
        check("skip_b_id", 32'(bus.rsp_id_out), 32'h0);
        bus.req_valid_in = 4'b0011;
        #1;
        check("skip_ptr1_ready", 32'(bus.req_ready_out), 32'h2);
        step();
        check("skip_ptr1_id", 32'(bus.rsp_id_out), 32'h1);
        bus.req_valid_in = '0;
        step();
        check("skip_done_cnt", 32'(bus.done_cnt_out), 32'd13);

        // Counter wrap then reset with a response pending
        pulse_reset();
        bus.req_valid_in = 4'b0001;
        for (int i = 0; i < 18; i++) step();
        bus.req_valid_in = '0;
        bus.rsp_ready_in = 1'b0;
        #1;
        check("wrap_done_cnt", 32'(bus.done_cnt_out), 32'd1);
        check("wrap_pending", 32'(bus.rsp_valid_out), 32'h1);
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.rsp_valid_out), 32'h0);
        check("mid_rst_id", 32'(bus.rsp_id_out), 32'h0);
        check("mid_rst_data", 32'(bus.rsp_data_out), 32'h0);
        check("mid_rst_done", 32'(bus.done_cnt_out), 32'h0);
        bus.rsp_ready_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_done", 32'(bus.done_cnt_out), 32'h0);
        check("post_rst_busy", 32'(bus.busy_out), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
